// File: rtl/uart_rx_top.sv
// ---------------------------------------------------------------------------
// uart_rx_top
//   UART receiver, the counterpart of tx_top. Frame format:
//   start(0), DATA_BITS data bits LSB first, even parity, stop(1).
//   The serial line passes through a 2-flop synchroniser before the FSM.
//   Bit k of the frame (0=start .. DATA_BITS+2=stop) is sampled
//   HALF + k*CLKS_PER_BIT cycles after the FSM first sees the line low.
//
// Ports
//   clk           system clock, posedge
//   rstn          asynchronous active-low reset
//   rx_data_in    serial line, idles high
//   rx_data_out   last received byte, held until the next frame completes
//   rx_valid      one-cycle strobe: rx_data_out and error flags updated
//   rx_busy       high while a frame (or a line break) is in progress
//   parity_error  pulses with rx_valid on parity mismatch
//   frame_error   pulses with rx_valid when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx_top #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_data_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 parity_error,
  output logic                 frame_error
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // With HALF=0 the start sample coincides with the detect cycle, so the
  // START state is skipped and the next sample is already data bit 1.
  localparam logic [CW-1:0] CNT_INIT = (HALF == 0) ? '0 : CW'(1);
  localparam logic [3:0]    BIT_INIT = (HALF == 0) ? 4'd1 : 4'd0;
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_sync;
  logic [CW-1:0]          r_clk_cnt;
  logic [3:0]             r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_valid, r_perr, r_ferr;

  logic                   w_rx_s;
  logic                   w_start;
  logic                   w_tick;
  logic                   w_done;

  assign w_rx_s = r_sync[1];

  // Synchroniser resets to the idle level so reset never looks like a start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx_data_in};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_tick      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_start     = 1'b1;
          w_state_nxt = (HALF == 0) ? S_DATA : S_START;
        end
      end
      S_START: begin
        w_tick = (r_clk_cnt == CNT_HALF);
        // Line back high at mid-start: glitch, drop it silently.
        if (w_tick) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        w_tick = (r_clk_cnt == CNT_LAST);
        if (w_tick && r_bit_cnt == BIT_LAST) w_state_nxt = S_PARITY;
      end
      S_PARITY: begin
        w_tick = (r_clk_cnt == CNT_LAST);
        if (w_tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_tick = (r_clk_cnt == CNT_LAST);
        if (w_tick) begin
          w_done      = 1'b1;
          w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // A low line here is the tail of a break, not a start bit.
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing and data capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else if (w_start) begin
      r_clk_cnt <= CNT_INIT;
      r_bit_cnt <= BIT_INIT;
    end else if (w_tick) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= r_bit_cnt + 4'd1;
      if (r_state == S_DATA)   r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      if (r_state == S_PARITY) r_par   <= w_rx_s;
    end else if (r_state != S_IDLE && r_state != S_BREAK) begin
      r_clk_cnt <= r_clk_cnt + CW'(1);
    end
  end

  // Result registers; flags are single-cycle pulses alongside rx_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_valid <= w_done;
      r_perr  <= w_done & (r_par != ^r_shift);
      r_ferr  <= w_done & ~w_rx_s;
      if (w_done) r_data_out <= r_shift;
    end
  end

  assign rx_data_out  = r_data_out;
  assign rx_valid     = r_valid;
  assign parity_error = r_perr;
  assign frame_error  = r_ferr;
  assign rx_busy      = (r_state != S_IDLE);

endmodule
